sar_conv_sequencer: RTL and testbench
=====================================

// Module: sar_conv_sequencer
// PURPOSE
//  Control/consumer stage wrapped around the SAR conversion FSM.
//  - Paces conversions: drives soc (hold high = SAR idle/reset, low = convert) and waits for eoc.
//  - Captures each 7-bit result and box-car averages 2**AVG_LOG2 results.
//  - Presents each average on a valid/ready output port.
// PARAMETERS
//  DW        7   ADC result width (matches SAR D/Q width)
//  AVG_LOG2  2   log2 of samples averaged per output; 0 = pass-through
//  PERIOD_W  16  width of the inter-conversion hold counter
//  TIMEOUT   16  max cycles from soc fall to eoc before abort (SAR_TIMEOUT_EN only)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  en         in   1         1 = run conversions continuously; 0 = finish current conversion, then idle
//  period     in   PERIOD_W  soc-high hold cycles between conversions; values <2 act as 2
//  soc        out  1         to SAR FSM: 1 = hold/restart, 0 = convert
//  eoc        in   1         from SAR FSM: 1 = conversion done
//  adc_q      in   DW        from SAR FSM: conversion result, stable while eoc=1
//  out_data   out  DW        averaged result
//  out_valid  out  1         out_data valid; held until accepted
//  out_ready  in   1         consumer accept; transfer when out_valid & out_ready
//  overrun    out  1         sticky: an average was dropped because the output was still full
//  busy       out  1         1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: soc=1, out_valid=0, out_data=0, overrun=0, busy=0.
//   - Reset also clears the accumulator, sample count and hold counter, and forces IDLE.
//   - Reset mid-conversion aborts it; soc=1 returns the SAR to its wait state.
//  FSM states: IDLE, CONV, CAPT, HOLD.
//   - IDLE: soc=1. On en=1, go to CONV.
//   - CONV: soc=0. On eoc=1, go to CAPT.
//   - CAPT (one cycle): soc=1. Latch adc_q into the accumulator: acc += adc_q; cnt++.
//       If cnt wraps to 0 (2**AVG_LOG2 samples), emit acc>>AVG_LOG2 (truncating) and clear acc.
//       Then go to HOLD.
//   - HOLD: soc=1; count max(period,2) cycles.
//       At terminal count: go to CONV if en=1, else IDLE.
//  Conversion pacing:
//   - eoc is sampled only in CONV; eoc seen in any other state is ignored.
//   - Nominal eoc latency is 9 cycles after soc falls.
//   - Sample-to-sample period = conversion + 1 + max(period,2) cycles.
//  en falling mid-conversion: the current conversion completes and is accumulated.
//   - The partial accumulator is then cleared on the IDLE entry; no partial average is emitted.
//  Arithmetic: acc is DW+AVG_LOG2 bits wide and cannot overflow.
//  Output handshake:
//   - out_valid rises the cycle after CAPT emits; out_data and out_valid are registered.
//   - out_data and out_valid hold stable until out_valid & out_ready; out_valid then drops the next cycle.
//   - Emit while out_valid=1 and out_ready=0: the new average is dropped, overrun is set and out_data is unchanged.
//   - Emit in the same cycle as the accepting transfer: the new value loads; no overrun.
//  overrun clears only on rst or on an en 1->0 transition.
// CONFIGURATION
//  SAR_TIMEOUT_EN defined:
//   - CONV counts cycles; at TIMEOUT without eoc, abort to HOLD with soc=1.
//   - The sample is discarded (acc and cnt unchanged), and a 1-cycle pulse is driven on an added output port timeout (1 bit).
//  SAR_TIMEOUT_EN undefined:
//   - No timeout counter and no timeout port; CONV waits on eoc indefinitely.
// STRUCTURE
//  Shared package sar_pkg: state encoding constants (IDLE/CONV/CAPT/HOLD), DW default, nominal SAR latency (9).
//  One sub-module, sar_avg_accum: accumulator, sample counter and shift.
//   - Inputs: clear, add_en, sample. Outputs: emit, avg.
//  FSM, hold counter and output register stay in the top level.
// TESTING (bench includes a behavioural SAR model; DW=7, AVG_LOG2=2, period=4)
//  1. rst held 3 cycles, en=0 -> soc=1, out_valid=0, busy=0 throughout.
//  2. en=1, SAR returns 10,11,12,13, out_ready=1 -> one output, out_data=11 (46>>2), overrun=0.
//  3. Samples 127 x4 -> out_data=127 (acc=508 fits in 9 bits); samples 0,0,0,3 -> out_data=0.
//  4. out_ready=0 across two averages (20 then 40) -> out_data stays 20, overrun=1 after the 2nd emit.
//     Then out_ready=1 -> one transfer of 20; en 1->0 -> overrun=0.
//  5. en dropped after 2 of 4 samples -> no output. Re-enable with 4 x 8 -> out_data=8 (partial discarded).
//     Also: period=0 -> soc high exactly 2 HOLD cycles (+1 CAPT).
//  6. rst asserted during CONV -> soc=1 the next cycle, acc cleared.
//     With SAR_TIMEOUT_EN and eoc stuck 0: timeout pulses at cycle 16 of CONV, no output.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer: state encoding,
// default result width and the nominal SAR conversion latency.
package sar_pkg;

    localparam int SAR_DW      = 7;
    localparam int SAR_LATENCY = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/sar_conv_sequencer_if.sv
// Averaged-result output stream (valid/ready) of the SAR conversion sequencer.
interface sar_conv_sequencer_if #(
    parameter int DW = 7
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sar_avg_accum.sv
// Box-car accumulator: sums 2**AVG_LOG2 samples and flags the sample that
// completes a block, presenting the truncated mean alongside it.
module sar_avg_accum #(
    parameter int DW       = 7,
    parameter int AVG_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          add_en,
    input  logic [DW-1:0] sample,
    output logic          emit,
    output logic [DW-1:0] avg
);
    localparam int AW = DW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc_r;
    logic [AW-1:0] sum_s;
    logic [CW-1:0] cnt_r;
    logic          last_s;

    // The sum including the current sample is what gets averaged on the last sample.
    assign sum_s  = acc_r + AW'(sample);
    assign last_s = (cnt_r == CNT_LAST);
    assign emit   = add_en && last_s;
    assign avg    = DW'(sum_s >> AVG_LOG2);

    // Accumulator and sample counter; both restart after each completed block.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_r <= {AW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (add_en) begin
            if (last_s) begin
                acc_r <= {AW{1'b0}};
                cnt_r <= {CW{1'b0}};
            end else begin
                acc_r <= sum_s;
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/sar_conv_sequencer.sv
// Paces SAR conversions, averages results and presents them on a valid/ready port.
// Optional feature: SAR_TIMEOUT_EN adds a CONV watchdog and a timeout pulse output.
module sar_conv_sequencer
    import sar_pkg::*;
#(
    parameter int DW       = SAR_DW,
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                soc,
    input  logic                eoc,
    input  logic [DW-1:0]       adc_q,
    sar_conv_sequencer_if.master out_if,
    output logic                overrun,
`ifdef SAR_TIMEOUT_EN
    output logic                timeout,
`endif
    output logic                busy
);
    state_t              state_r, state_s;
    logic                soc_r, busy_r, out_valid_r, overrun_r, en_d_r;
    logic [DW-1:0]       out_data_r, sample_r, avg_s;
    logic [PERIOD_W-1:0] hold_cnt_r, hold_len_s;
    logic                hold_done_s, abort_s, emit_s;

    assign hold_len_s  = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
    assign hold_done_s = (hold_cnt_r >= hold_len_s);

`ifdef SAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_r;
    logic          timeout_r;

    assign abort_s = (state_r == ST_CONV) && !eoc && (tmo_cnt_r == TW'(TIMEOUT - 1));
    assign timeout = timeout_r;

    // Cycles spent in CONV; the pulse marks an abandoned conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            tmo_cnt_r <= (state_r == ST_CONV) ? tmo_cnt_r + TW'(1) : {TW{1'b0}};
            timeout_r <= abort_s;
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (en) state_s = ST_CONV; else state_s = ST_IDLE;
            ST_CONV: begin
                if (eoc)          state_s = ST_CAPT;
                else if (abort_s) state_s = ST_HOLD;
                else              state_s = ST_CONV;
            end
            ST_CAPT: state_s = ST_HOLD;
            ST_HOLD: begin
                if (hold_done_s) state_s = en ? ST_CONV : ST_IDLE;
                else             state_s = ST_HOLD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, hold counter and sample latch; soc/busy are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            soc_r      <= 1'b1;
            busy_r     <= 1'b0;
            hold_cnt_r <= {PERIOD_W{1'b0}};
            sample_r   <= {DW{1'b0}};
        end else begin
            state_r    <= state_s;
            soc_r      <= (state_s != ST_CONV);
            busy_r     <= (state_s != ST_IDLE);
            hold_cnt_r <= (state_r == ST_HOLD) ? hold_cnt_r + PERIOD_W'(1) : PERIOD_W'(1);
            sample_r   <= (state_r == ST_CONV && eoc) ? adc_q : sample_r;
        end
    end

    sar_avg_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_r == ST_IDLE),
        .add_en (state_r == ST_CAPT),
        .sample (sample_r),
        .emit   (emit_s),
        .avg    (avg_s)
    );

    // Output register and sticky overrun; a same-cycle accept frees the slot for a new average.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
            en_d_r      <= 1'b0;
        end else begin
            en_d_r <= en;
            if (emit_s && out_valid_r && !out_if.out_ready) overrun_r <= 1'b1;
            else if (en_d_r && !en)                         overrun_r <= 1'b0;
            else                                            overrun_r <= overrun_r;
            if (emit_s && (!out_valid_r || out_if.out_ready)) begin
                out_data_r  <= avg_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_if.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign soc              = soc_r;
    assign busy             = busy_r;
    assign overrun          = overrun_r;
    assign out_if.out_data  = out_data_r;
    assign out_if.out_valid = out_valid_r;
endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed bench for sar_conv_sequencer with a behavioural SAR model and an
// expected-average scoreboard; DW=7, AVG_LOG2=2, period=4 unless stated.
module tb_sar_conv_sequencer;
    import sar_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] period = 16'd4;
    logic        soc, overrun, busy;
    logic        eoc = 1'b0;
    logic [6:0]  adc_q = 7'd0;
    logic        sar_stuck = 1'b0;
`ifdef SAR_TIMEOUT_EN
    logic        timeout;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          sar_cnt = 0;
    int          sar_taken = 0;
    logic [6:0]  sar_q[$];
    logic [6:0]  exp_q[$];

    sar_conv_sequencer_if #(.DW(7)) oif ();

    sar_conv_sequencer #(.DW(7), .AVG_LOG2(2), .PERIOD_W(16), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .period  (period),
        .soc     (soc),
        .eoc     (eoc),
        .adc_q   (adc_q),
        .out_if  (oif.master),
        .overrun (overrun),
`ifdef SAR_TIMEOUT_EN
        .timeout (timeout),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // SAR model: eoc rises SAR_LATENCY cycles after soc falls, result stays until soc rises.
    always @(posedge clk) begin
        if (rst || soc) begin
            sar_cnt <= 0;
            eoc     <= 1'b0;
        end else if (!eoc && !sar_stuck) begin
            if (sar_cnt == SAR_LATENCY - 1) begin
                eoc       <= 1'b1;
                sar_taken <= sar_taken + 1;
                if (sar_q.size() > 0) adc_q <= sar_q.pop_front();
                else                  adc_q <= 7'd0;
            end else begin
                sar_cnt <= sar_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_block(input logic [6:0] a, input logic [6:0] b,
                              input logic [6:0] c, input logic [6:0] d, input bit expect_out);
        int sum;
        sar_q.push_back(a); sar_q.push_back(b); sar_q.push_back(c); sar_q.push_back(d);
        sum = int'(a) + int'(b) + int'(c) + int'(d);
        if (expect_out) exp_q.push_back(7'(sum / 4));
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        logic [6:0] e;
        while (!oif.out_valid && k < 400) begin @(negedge clk); k++; end
        check({tag, "_valid"}, 32'(oif.out_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
        check({tag, "_data"}, 32'(oif.out_data), 32'(e));
        @(negedge clk);
    endtask

    task automatic wait_soc(input logic v);
        int k = 0;
        while (soc !== v && k < 200) begin @(negedge clk); k++; end
        check("wait_soc", 32'(soc), 32'(v));
    endtask

    task automatic wait_taken(input int n);
        int k = 0;
        while (sar_taken < n && k < 400) begin @(negedge clk); k++; end
        check("wait_taken", 32'(sar_taken >= n), 32'd1);
    endtask

    task automatic go_idle(input string tag);
        en = 1'b0;
        repeat (14) @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_soc"}, 32'(soc), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        oif.out_ready = 1'b1;

        // 1: reset held 3 cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_soc", 32'(soc), 32'd1);
            check("rst_valid", 32'(oif.out_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_data", 32'(oif.out_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // 2 and 3: three consecutive blocks with continuous conversion
        push_block(7'd10, 7'd11, 7'd12, 7'd13, 1'b1);
        push_block(7'd127, 7'd127, 7'd127, 7'd127, 1'b1);
        push_block(7'd0, 7'd0, 7'd0, 7'd3, 1'b1);
        en = 1'b1;
        wait_out("avg_10_13");
        check("ovr_after_first", 32'(overrun), 32'd0);
        check("valid_dropped", 32'(oif.out_valid), 32'd0);
        wait_out("avg_127");
        wait_out("avg_0003");
        go_idle("idle_after_3");

        // 4: consumer stalls across two averages
        oif.out_ready = 1'b0;
        push_block(7'd20, 7'd20, 7'd20, 7'd20, 1'b1);
        push_block(7'd40, 7'd40, 7'd40, 7'd40, 1'b0);
        en = 1'b1;
        wait_out("stall_20");
        check("ovr_before_2nd", 32'(overrun), 32'd0);
        n = 0;
        while (!overrun && n < 400) begin @(negedge clk); n++; end
        check("ovr_set", 32'(overrun), 32'd1);
        check("stall_hold_data", 32'(oif.out_data), 32'd20);
        check("stall_hold_valid", 32'(oif.out_valid), 32'd1);
        oif.out_ready = 1'b1;
        @(negedge clk);
        check("one_transfer", 32'(oif.out_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("ovr_clr_en_fall", 32'(overrun), 32'd0);
        go_idle("idle_after_stall");

        // 5: en dropped after 2 of 4 samples; partial block discarded
        base = sar_taken;
        sar_q.push_back(7'd50);
        sar_q.push_back(7'd60);
        en = 1'b1;
        wait_taken(base + 2);
        go_idle("partial_idle");
        check("partial_no_out", 32'(oif.out_valid), 32'd0);
        push_block(7'd8, 7'd8, 7'd8, 7'd8, 1'b1);
        en = 1'b1;
        wait_out("avg_8");
        go_idle("idle_after_8");

        // 5b: period=0 acts as 2 -> soc high for CAPT + 2 HOLD cycles
        period = 16'd0;
        push_block(7'd5, 7'd5, 7'd5, 7'd5, 1'b1);
        en = 1'b1;
        wait_soc(1'b0);
        wait_soc(1'b1);
        n = 0;
        while (soc && n < 50) begin @(negedge clk); n++; end
        check("period0_high", 32'(n), 32'd3);
        wait_out("avg_5");
        go_idle("idle_after_p0");
        period = 16'd4;

        // 6: reset during CONV after two accumulated samples
        base = sar_taken;
        sar_q.push_back(7'd100);
        sar_q.push_back(7'd100);
        en = 1'b1;
        wait_taken(base + 2);
        wait_soc(1'b1);
        wait_soc(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        check("rst_conv_soc", 32'(soc), 32'd1);
        check("rst_conv_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        push_block(7'd16, 7'd16, 7'd16, 7'd16, 1'b1);
        en = 1'b1;
        wait_out("avg_16_after_rst");
        go_idle("idle_final");

`ifdef SAR_TIMEOUT_EN
        sar_stuck = 1'b1;
        en = 1'b1;
        n = 0;
        while (!timeout && n < 60) begin @(negedge clk); n++; end
        check("timeout_pulse", 32'(timeout), 32'd1);
        @(negedge clk);
        check("timeout_1cyc", 32'(timeout), 32'd0);
        check("timeout_no_out", 32'(oif.out_valid), 32'd0);
        go_idle("idle_timeout");
        sar_stuck = 1'b0;
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
